// File: rtl/moore_seq_det.sv
// Moore FSM that scans a serial bit stream for the pattern 0-1-1-0.
// Overlapping matches are recognised: the trailing "0" or "01" of a match
// is reused as the prefix of the next one. data_out is a pure decode of
// the state register, so data_in never reaches it combinationally.
module moore_seq_det (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  // State encoding: each code names the longest useful prefix seen so far.
  localparam logic [2:0] S0 = 3'd0;  // no useful prefix
  localparam logic [2:0] S1 = 3'd1;  // "0"
  localparam logic [2:0] S2 = 3'd2;  // "01"
  localparam logic [2:0] S3 = 3'd3;  // "011"
  localparam logic [2:0] S4 = 3'd4;  // "0110" -> match

  logic [2:0] state_q;
  logic [2:0] state_d;

  // Next-state logic; codes 5..7 are unreachable and recover to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = data_in ? S0 : S1;
      S1:      state_d = data_in ? S2 : S1;
      S2:      state_d = data_in ? S3 : S1;
      S3:      state_d = data_in ? S0 : S4;
      // After a match, the final 0 starts a new prefix: "0" or "01".
      S4:      state_d = data_in ? S2 : S1;
      default: state_d = S0;
    endcase
  end

  // State register with synchronous reset taking priority over every transition.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  // Moore output: high only while sitting in the match state.
  always_comb begin
    data_out = (state_q == S4);
  end

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed bench for moore_seq_det: reset, single match, overlap, near
// misses, mid-operation reset and a long mixed stream.
module tb_moore_seq_det;

  logic clk;
  logic rst;
  logic data_in;
  logic data_out;

  int errors = 0;
  int checks = 0;

  moore_seq_det dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic test_reset();
    rst = 1'b1; data_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (data_out !== 1'b0) begin
        errors++; $display("FAIL reset_out edge%0d: got %b want 0", i, data_out);
      end
      checks++;
      if (dut.state_q !== 3'd0) begin
        errors++; $display("FAIL reset_state edge%0d: got %0d want 0", i, dut.state_q);
      end
    end
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] bits = 5'b01101;
    logic [4:0] exp  = 5'b00010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data_in = bits[4-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp[4-i]) begin
        errors++; $display("FAIL single bit%0d: got %b want %b", i+1, data_out, exp[4-i]);
      end
      // While the match flag is up, wiggling data_in must not disturb it.
      if (i == 3) begin
        data_in = 1'b1; #1;
        checks++;
        if (data_out !== 1'b1) begin
          errors++; $display("FAIL moore_out: got %b want 1", data_out);
        end
        data_in = 1'b0; #1;
        checks++;
        if (data_out !== 1'b1) begin
          errors++; $display("FAIL moore_out2: got %b want 1", data_out);
        end
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b0110110;
    logic [6:0] exp  = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      data_in = bits[6-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp[6-i]) begin
        errors++; $display("FAIL overlap bit%0d: got %b want %b", i+1, data_out, exp[6-i]);
      end
    end
  endtask

  task automatic test_near_miss();
    logic [9:0] bits = 10'b01110_10110;
    logic [9:0] exp  = 10'b00000_00001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      data_in = bits[9-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp[9-i]) begin
        errors++; $display("FAIL near_miss bit%0d: got %b want %b", i+1, data_out, exp[9-i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] pre  = 3'b011;
    logic [2:0] post = 3'b110;
    logic [3:0] pat  = 4'b0110;
    do_reset();
    // Prefix 011 then reset: the following 110 must not complete a match.
    for (int i = 0; i < 3; i++) begin
      data_in = pre[2-i];
      @(posedge clk); #1;
    end
    rst = 1'b1; data_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dut.state_q !== 3'd0) begin
      errors++; $display("FAIL midreset_state: got %0d want 0", dut.state_q);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = post[2-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== 1'b0) begin
        errors++; $display("FAIL midreset_prefix bit%0d: got %b want 0", i+1, data_out);
      end
    end
    // Reset while the flag is high; the 0 sampled with it must not start a prefix.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_in = pat[3-i];
      @(posedge clk); #1;
    end
    checks++;
    if (data_out !== 1'b1) begin
      errors++; $display("FAIL detect_before_reset: got %b want 1", data_out);
    end
    rst = 1'b1; data_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (data_out !== 1'b0) begin
      errors++; $display("FAIL reset_in_detect: got %b want 0", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = post[2-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== 1'b0) begin
        errors++; $display("FAIL after_detect_reset bit%0d: got %b want 0", i+1, data_out);
      end
    end
  endtask

  task automatic test_long_stream();
    logic [12:0] bits = 13'b0011011010110;
    logic [12:0] exp  = 13'b0000100100001;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      data_in = bits[12-i];
      @(posedge clk); #1;
      checks++;
      if (data_out !== exp[12-i]) begin
        errors++; $display("FAIL long bit%0d: got %b want %b", i+1, data_out, exp[12-i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_long_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
